e203_ifu_iq: RTL and testbench
==============================

# e203_ifu_iq

Instruction queue between the IFU's IR-stage output (`ifu_o_*`) and the EXU decode/dispatch input. It stores up to DEPTH fetched instructions with their sideband (PC, fault flags, register indices, prediction bits). This decouples IFU fetch bursts from EXU stalls without a combinational path from EXU ready back into the IFU. A flush input drops all queued entries in one cycle so the EXU never sees wrong-path instructions.

## Interface
- DEPTH, 2, number of entries; power of two, 2..8
- PC_W, 32, PC width (`E203_PC_SIZE`)
- IR_W, 32, instruction width (`E203_INSTR_SIZE`)
- RFIDX_W, 5, register index width (`E203_RFIDX_WIDTH`)

Ports. Sync reset is active-high, with one clock domain.
- clk  in  1  clock; all state is updated on the rising edge
- rst  in  1  synchronous reset, active-high
- i_valid  in  1  IFU output valid (`ifu_o_valid`)
- i_ready  out  1  queue can accept (drives `ifu_o_ready`)
- i_ir, i_pc  in  IR_W, PC_W  instruction, PC
- i_pc_vld, i_misalgn, i_buserr, i_prdt_taken, i_muldiv_b2b  in  1 each  sideband flags
- i_rs1idx, i_rs2idx  in  RFIDX_W each  pre-decoded source indices
- o_valid  out  1  head entry valid to EXU
- o_ready  in  1  EXU accepts head
- o_ir, o_pc, o_pc_vld, o_misalgn, o_buserr, o_prdt_taken, o_muldiv_b2b, o_rs1idx, o_rs2idx  out  as input counterparts  head entry payload
- flush  in  1  discard all entries (pipe flush / exception commit)
- count  out  $clog2(DEPTH+1)  occupied entries
- empty, full  out  1  count==0, count==DEPTH

## Operation
- Storage: circular buffer of DEPTH entries, with rd_ptr and wr_ptr of log2(DEPTH) bits each, wrapping modulo DEPTH.
  - Occupancy is tracked by `count`, not by pointer comparison.
- push = i_valid & i_ready; pop = o_valid & o_ready.
- i_ready = !full, registered-state only. It has no dependence on o_ready, so a full queue refuses a push even when it is popping in the same cycle.
- o_valid = !empty. The o_* payload is the head entry, read directly from storage.
- A push writes to entry[wr_ptr] and advances wr_ptr. A pop advances rd_ptr. The count changes as follows:
  - +1 on push only
  - −1 on pop only
  - unchanged on push and pop together
- Flush has priority over push and pop:
  - count, rd_ptr and wr_ptr are cleared to 0.
  - Any push in the same cycle is discarded.
  - A pop in the same cycle still completes the EXU handshake; the entry is consumed, and the EXU flushes it itself.
- Payload is passed through unmodified. The queue does not interpret misalgn or buserr; faulted entries are queued and popped like normal ones.
- Entry storage needs no reset. Outputs are only qualified by o_valid.

## Timing
- Reset (rst=1 at a rising edge) clears:
  - count=0, rd_ptr=0, wr_ptr=0
  - Resulting outputs: o_valid=0, empty=1, full=0, i_ready=1
- Payload outputs are don't-care while o_valid=0. Bench checks payload only when o_valid=1.
- Latency: an instruction pushed in cycle N is visible at o_valid/o_* in cycle N+1. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle while 0 < count < DEPTH.
- When full, a push is accepted the cycle after the pop that frees an entry.
- Flush asserted in cycle N gives o_valid=0 and count=0 in cycle N+1. i_ready is unaffected in cycle N (it is state-based).
- Reset asserted mid-operation behaves identically to flush and also clears count. rst overrides flush, push and pop.
- Handshake rules:
  - o_* are stable while o_valid=1 and o_ready=0, unless flush or rst is asserted.
  - i_ready never drops without a push having filled the last entry.

## Test plan
- Reset with i_valid=1 → the cycle after rst deasserts, o_valid=0, count=0, i_ready=1. The first push (pc=0x8000_0000) appears at o_pc the next cycle with o_valid=1.
- DEPTH=2: push 0x1000, then 0x1004, with o_ready=0 → full=1, i_ready=0, and a third i_valid is not accepted. Raising o_ready pops 0x1000, then 0x1004, in order. The third push is accepted one cycle after the first pop.
- Steady stream of 8 pushes with o_ready=1 and one entry resident → one pop per cycle, PCs 0x0..0x1C in order. wr_ptr and rd_ptr wrap at least twice and count stays at 1.
- Two entries queued, then flush asserted together with i_valid=1 (pc=0x2000) and o_ready=1 → the next cycle shows count=0 and o_valid=0, and 0x2000 is never output.
- o_ready held 0 for 5 cycles on a head with i_misalgn=1, i_buserr=1, ir=0xDEADBEEF → o_* stable all 5 cycles, and the flags are popped unchanged.
- rst asserted while count=2 with push and pop active → the next cycle shows count=0, o_valid=0, i_ready=1.

Source files
------------

// File: rtl/e203_ifu_iq.sv
// e203_ifu_iq: instruction queue between the IFU IR-stage output and EXU
// decode/dispatch. Circular buffer of DEPTH entries holding the instruction
// and its sideband. Occupancy is tracked by an explicit counter. A flush
// drops every queued entry in one cycle.
//
// Handshake: a transfer happens on a side only in a cycle where valid and
// ready are both high at the rising edge. Valid never waits on ready.
// i_ready depends only on registered occupancy, so there is no combinational
// path from o_ready back to the IFU. A full queue refuses a push even in a
// cycle where it pops.
module e203_ifu_iq #(
  parameter int DEPTH   = 2,
  parameter int PC_W    = 32,
  parameter int IR_W    = 32,
  parameter int RFIDX_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  output logic                       i_ready,
  input  logic [IR_W-1:0]            i_ir,
  input  logic [PC_W-1:0]            i_pc,
  input  logic                       i_pc_vld,
  input  logic                       i_misalgn,
  input  logic                       i_buserr,
  input  logic                       i_prdt_taken,
  input  logic                       i_muldiv_b2b,
  input  logic [RFIDX_W-1:0]         i_rs1idx,
  input  logic [RFIDX_W-1:0]         i_rs2idx,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [IR_W-1:0]            o_ir,
  output logic [PC_W-1:0]            o_pc,
  output logic                       o_pc_vld,
  output logic                       o_misalgn,
  output logic                       o_buserr,
  output logic                       o_prdt_taken,
  output logic                       o_muldiv_b2b,
  output logic [RFIDX_W-1:0]         o_rs1idx,
  output logic [RFIDX_W-1:0]         o_rs2idx,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int E_W   = IR_W + PC_W + 5 + 2*RFIDX_W;

  // Payload storage; contents are qualified only by o_valid, so no reset.
  logic [E_W-1:0]   mem [DEPTH];
  logic [E_W-1:0]   wr_data;
  logic [E_W-1:0]   head;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             push;
  logic             pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign i_ready = ~full;
  assign o_valid = ~empty;
  assign push    = i_valid & i_ready;
  assign pop     = o_valid & o_ready;

  assign wr_data = {i_ir, i_pc, i_pc_vld, i_misalgn, i_buserr, i_prdt_taken,
                    i_muldiv_b2b, i_rs1idx, i_rs2idx};
  assign head    = mem[rd_ptr];
  assign {o_ir, o_pc, o_pc_vld, o_misalgn, o_buserr, o_prdt_taken,
          o_muldiv_b2b, o_rs1idx, o_rs2idx} = head;

  // Pointer and occupancy update; reset beats flush, flush beats push/pop.
  // A pop coinciding with flush is still a completed handshake, but since
  // everything is cleared it needs no separate handling here.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Entry write at the tail; discarded pushes (flush/reset) never land.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_e203_ifu_iq.sv
// Directed bench for e203_ifu_iq (DEPTH=2): a table of per-cycle input
// records with the outputs expected in that cycle, plus an expected queue of
// the PCs the EXU side must receive, in order.
module tb_e203_ifu_iq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_ready;
  logic [31:0] i_ir = '0;
  logic [31:0] i_pc = '0;
  logic        i_pc_vld = 1'b0, i_misalgn = 1'b0, i_buserr = 1'b0;
  logic        i_prdt_taken = 1'b0, i_muldiv_b2b = 1'b0;
  logic [4:0]  i_rs1idx = '0, i_rs2idx = '0;
  logic        o_valid;
  logic        o_ready = 1'b0;
  logic [31:0] o_ir, o_pc;
  logic        o_pc_vld, o_misalgn, o_buserr, o_prdt_taken, o_muldiv_b2b;
  logic [4:0]  o_rs1idx, o_rs2idx;
  logic        flush = 1'b0;
  logic [1:0]  count;
  logic        empty, full;

  e203_ifu_iq #(.DEPTH(2), .PC_W(32), .IR_W(32), .RFIDX_W(5)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_ir(i_ir), .i_pc(i_pc),
    .i_pc_vld(i_pc_vld), .i_misalgn(i_misalgn), .i_buserr(i_buserr),
    .i_prdt_taken(i_prdt_taken), .i_muldiv_b2b(i_muldiv_b2b),
    .i_rs1idx(i_rs1idx), .i_rs2idx(i_rs2idx),
    .o_valid(o_valid), .o_ready(o_ready), .o_ir(o_ir), .o_pc(o_pc),
    .o_pc_vld(o_pc_vld), .o_misalgn(o_misalgn), .o_buserr(o_buserr),
    .o_prdt_taken(o_prdt_taken), .o_muldiv_b2b(o_muldiv_b2b),
    .o_rs1idx(o_rs1idx), .o_rs2idx(o_rs2idx),
    .flush(flush), .count(count), .empty(empty), .full(full)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    bit          rst;
    bit          iv;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [4:0]  flg;   // {pc_vld, misalgn, buserr, prdt_taken, muldiv_b2b}
    bit          ordy;
    bit          fl;
    bit          ev;
    logic [31:0] epc;
    logic [31:0] eir;
    logic [4:0]  eflg;
    logic [1:0]  ecnt;
    bit          eird;
  } vec_t;

  vec_t        vt[$];
  logic [31:0] exp_q[$];
  int          n_chk = 0;
  int          n_pass = 0;

  function automatic logic [31:0] ir_of(logic [31:0] pc);
    return pc ^ 32'h5A5A_0013;
  endfunction

  function automatic logic [4:0] flg_of(logic [31:0] pc);
    return pc[6:2] ^ 5'b10101;
  endfunction

  function automatic void add_v(bit r, bit iv, logic [31:0] pc, logic [31:0] ir,
                                logic [4:0] flg, bit ordy, bit fl, bit ev,
                                logic [31:0] epc, logic [31:0] eir,
                                logic [4:0] eflg, logic [1:0] ecnt, bit eird);
    vec_t v;
    v.chk = 1'b1; v.rst = r; v.iv = iv; v.pc = pc; v.ir = ir; v.flg = flg;
    v.ordy = ordy; v.fl = fl; v.ev = ev; v.epc = epc; v.eir = eir;
    v.eflg = eflg; v.ecnt = ecnt; v.eird = eird;
    vt.push_back(v);
  endfunction

  function automatic void add_n(bit iv, logic [31:0] pc, bit ordy, bit fl,
                                bit ev, logic [31:0] epc, logic [1:0] ecnt,
                                bit eird);
    add_v(1'b0, iv, pc, ir_of(pc), flg_of(pc), ordy, fl, ev, epc, ir_of(epc),
          flg_of(epc), ecnt, eird);
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Driver: drive one record after the falling edge, then check the outputs
  // that the registered state presents in this cycle.
  task automatic apply(vec_t v);
    @(negedge clk);
    rst = v.rst; i_valid = v.iv; i_pc = v.pc; i_ir = v.ir;
    {i_pc_vld, i_misalgn, i_buserr, i_prdt_taken, i_muldiv_b2b} = v.flg;
    i_rs1idx = v.pc[11:7]; i_rs2idx = v.pc[16:12];
    o_ready = v.ordy; flush = v.fl;
    #1;
    if (v.chk) begin
      chk("o_valid", 64'(o_valid), 64'(v.ev));
      chk("count",   64'(count),   64'(v.ecnt));
      chk("i_ready", 64'(i_ready), 64'(v.eird));
      chk("empty",   64'(empty),   64'(v.ecnt == 2'd0));
      chk("full",    64'(full),    64'(v.ecnt == 2'd2));
      if (v.ev) begin
        chk("o_pc", 64'(o_pc), 64'(v.epc));
        chk("o_ir", 64'(o_ir), 64'(v.eir));
        chk("o_flags", 64'({o_pc_vld, o_misalgn, o_buserr, o_prdt_taken,
                            o_muldiv_b2b}), 64'(v.eflg));
        chk("o_rs1idx", 64'(o_rs1idx), 64'(v.epc[11:7]));
        chk("o_rs2idx", 64'(o_rs2idx), 64'(v.epc[16:12]));
      end
    end
    // Scoreboard: a handshake about to complete must deliver the next PC.
    if (o_valid === 1'b1 && o_ready && !rst) begin
      if (exp_q.size() == 0) chk("pop_unexpected", 64'(o_pc), 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("pop_pc", 64'(o_pc), 64'(exp_q.pop_front()));
    end
  endtask

  initial begin
    // Reset held with i_valid=1, then first push after release.
    add_n(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1);
    vt[0].chk = 1'b0; vt[0].rst = 1'b1;
    add_n(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1);
    add_n(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 2'd1, 1'b1);
    add_n(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1);

    // Fill to full, refused third push, in-order drain.
    add_n(1'b1, 32'h1000, 1'b0, 1'b0, 1'b0, 32'h0,    2'd0, 1'b1);
    add_n(1'b1, 32'h1004, 1'b0, 1'b0, 1'b1, 32'h1000, 2'd1, 1'b1);
    add_n(1'b1, 32'h1008, 1'b0, 1'b0, 1'b1, 32'h1000, 2'd2, 1'b0);
    add_n(1'b1, 32'h1008, 1'b1, 1'b0, 1'b1, 32'h1000, 2'd2, 1'b0);
    add_n(1'b1, 32'h1008, 1'b1, 1'b0, 1'b1, 32'h1004, 2'd1, 1'b1);
    add_n(1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 32'h1008, 2'd1, 1'b1);
    add_n(1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    2'd0, 1'b1);

    // Steady stream: one resident entry, push and pop every cycle.
    add_n(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1);
    for (int i = 1; i < 8; i++)
      add_n(1'b1, 32'(4*i), 1'b1, 1'b0, 1'b1, 32'(4*(i-1)), 2'd1, 1'b1);
    add_n(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h1C, 2'd1, 1'b1);
    add_n(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,  2'd0, 1'b1);

    // Flush while full with push+pop, then flush with a push the queue could take.
    add_n(1'b1, 32'h3000, 1'b0, 1'b0, 1'b0, 32'h0,    2'd0, 1'b1);
    add_n(1'b1, 32'h3004, 1'b0, 1'b0, 1'b1, 32'h3000, 2'd1, 1'b1);
    add_n(1'b1, 32'h2000, 1'b1, 1'b1, 1'b1, 32'h3000, 2'd2, 1'b0);
    add_n(1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    2'd0, 1'b1);
    add_n(1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    2'd0, 1'b1);
    add_n(1'b1, 32'h3008, 1'b0, 1'b0, 1'b0, 32'h0,    2'd0, 1'b1);
    add_n(1'b1, 32'h2004, 1'b0, 1'b1, 1'b1, 32'h3008, 2'd1, 1'b1);
    add_n(1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    2'd0, 1'b1);
    add_n(1'b1, 32'h3010, 1'b0, 1'b0, 1'b0, 32'h0,    2'd0, 1'b1);
    add_n(1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 32'h3010, 2'd1, 1'b1);
    add_n(1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    2'd0, 1'b1);

    // Faulted head held under back-pressure for 5 cycles, then popped.
    add_v(1'b0, 1'b1, 32'h4000, 32'hDEAD_BEEF, 5'b11100, 1'b0, 1'b0,
          1'b0, 32'h0, 32'h0, 5'b0, 2'd0, 1'b1);
    for (int i = 0; i < 5; i++)
      add_v(1'b0, 1'b0, 32'h0, ir_of(32'h0), flg_of(32'h0), 1'b0, 1'b0,
            1'b1, 32'h4000, 32'hDEAD_BEEF, 5'b11100, 2'd1, 1'b1);
    add_v(1'b0, 1'b0, 32'h0, ir_of(32'h0), flg_of(32'h0), 1'b1, 1'b0,
          1'b1, 32'h4000, 32'hDEAD_BEEF, 5'b11100, 2'd1, 1'b1);
    add_n(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1);

    // Reset mid-operation with count=2 and push+pop requested.
    add_n(1'b1, 32'h5000, 1'b0, 1'b0, 1'b0, 32'h0,    2'd0, 1'b1);
    add_n(1'b1, 32'h5004, 1'b0, 1'b0, 1'b1, 32'h5000, 2'd1, 1'b1);
    add_v(1'b1, 1'b1, 32'h5008, ir_of(32'h5008), flg_of(32'h5008), 1'b1, 1'b0,
          1'b1, 32'h5000, ir_of(32'h5000), flg_of(32'h5000), 2'd2, 1'b0);
    add_n(1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    2'd0, 1'b1);
    add_n(1'b1, 32'h6000, 1'b0, 1'b0, 1'b0, 32'h0,    2'd0, 1'b1);
    add_n(1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 32'h6000, 2'd1, 1'b1);
    add_n(1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    2'd0, 1'b1);

    // PCs the EXU must receive, in order.
    exp_q = '{32'h8000_0000, 32'h1000, 32'h1004, 32'h1008,
              32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C,
              32'h3000, 32'h3010, 32'h4000, 32'h6000};

    foreach (vt[i]) apply(vt[i]);

    chk("sb_drain", 64'(exp_q.size()), 64'd0);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
